// File: rtl/led_blink_array_if.sv
// rtl/led_blink_array_if.sv - memory-mapped register bus for the LED blink controller
interface led_blink_array_if;
    logic        chip_select;
    logic        read_enable;
    logic        write_enable;
    logic [4:0]  address_bus;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (
        output chip_select,
        output read_enable,
        output write_enable,
        output address_bus,
        output write_data,
        input  read_data
    );

    modport slave (
        input  chip_select,
        input  read_enable,
        input  write_enable,
        input  address_bus,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/led_blink_array.sv
// rtl/led_blink_array.sv - N-channel LED controller with off/on/blink/one-shot modes
module led_blink_array #(
    parameter int N          = 4,
    parameter int RATE_W     = 16,
    parameter int CLK_PER_MS = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    led_blink_array_if.slave     bus,
    output logic [N-1:0]         LED
);
    localparam int              PS_W         = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PS_W-1:0] PS_MAX       = PS_W'(CLK_PER_MS - 1);
    localparam logic [4:0]      ADDR_MODE    = 5'd16;
    localparam logic [4:0]      ADDR_RESTART = 5'd17;
    localparam logic [4:0]      ADDR_STATUS  = 5'd18;

    logic [PS_W-1:0]   ps_cnt;
    logic              tick;

    logic [RATE_W-1:0] rate  [N];
    logic [RATE_W-1:0] cnt   [N];
    logic [RATE_W-1:0] cnt_n [N];
    logic [2*N-1:0]    mode;
    logic [2*N-1:0]    mode_n;
    logic [N-1:0]      led;
    logic [N-1:0]      led_n;

    logic              wr_en;
    logic              rd_en;
    logic              mode_wr;
    logic              restart_wr;
    logic [31:0]       rd_mux;

    // Write-data bits above the active register fields are deliberately dropped.
    logic              unused_wdata;
    assign unused_wdata = ^bus.write_data;

    assign wr_en      = bus.chip_select && bus.write_enable;
    assign rd_en      = bus.chip_select && bus.read_enable;
    assign mode_wr    = wr_en && (bus.address_bus == ADDR_MODE);
    assign restart_wr = wr_en && (bus.address_bus == ADDR_RESTART);
    assign tick       = (ps_cnt == PS_MAX);
    assign LED        = led;

    // Free-running millisecond prescaler; never resynchronised to channel activity.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    // Per-channel next state: entry/restart first, then mode behaviour, CPU mode write beats hardware clear.
    always_comb begin
        logic [1:0] cur_m;
        logic [1:0] new_m;
        logic       at_end;
        logic       os_clr;
        mode_n = mode;
        led_n  = led;
        cur_m  = '0;
        new_m  = '0;
        at_end = 1'b0;
        os_clr = 1'b0;
        for (int i = 0; i < N; i++) begin
            cnt_n[i] = cnt[i];
            cur_m    = mode[2*i +: 2];
            new_m    = bus.write_data[2*i +: 2];
            at_end   = ({1'b0, cnt[i]} + (RATE_W+1)'(1)) >= {1'b0, rate[i]};
            os_clr   = 1'b0;
            if ((mode_wr && (new_m != cur_m) && new_m[1]) ||
                (restart_wr && bus.write_data[i] && cur_m[1])) begin
                led_n[i] = 1'b1;
                cnt_n[i] = '0;
            end else begin
                case (cur_m)
                    2'b00: begin
                        led_n[i] = 1'b0;
                        cnt_n[i] = '0;
                    end
                    2'b01: begin
                        led_n[i] = 1'b1;
                        cnt_n[i] = '0;
                    end
                    2'b10: begin
                        if (rate[i] == '0) begin
                            led_n[i] = 1'b0;
                            cnt_n[i] = '0;
                        end else if (tick) begin
                            if (at_end) begin
                                led_n[i] = ~led[i];
                                cnt_n[i] = '0;
                            end else begin
                                cnt_n[i] = cnt[i] + RATE_W'(1);
                            end
                        end
                    end
                    default: begin
                        if (rate[i] == '0) begin
                            led_n[i] = 1'b0;
                            cnt_n[i] = '0;
                            os_clr   = 1'b1;
                        end else if (tick) begin
                            if (at_end) begin
                                led_n[i] = 1'b0;
                                cnt_n[i] = '0;
                                os_clr   = 1'b1;
                            end else begin
                                cnt_n[i] = cnt[i] + RATE_W'(1);
                            end
                        end
                    end
                endcase
            end
            if (mode_wr) begin
                mode_n[2*i +: 2] = new_m;
            end else if (os_clr) begin
                mode_n[2*i +: 2] = 2'b00;
            end
        end
    end

    // Register file and channel state.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode <= '0;
            led  <= '0;
            for (int i = 0; i < N; i++) begin
                rate[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            mode <= mode_n;
            led  <= led_n;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= cnt_n[i];
                if (wr_en && (bus.address_bus == 5'(i))) begin
                    rate[i] <= bus.write_data[RATE_W-1:0];
                end
            end
        end
    end

    // Read mux over pre-write register contents; reserved addresses read 0.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.address_bus == 5'(i)) begin
                rd_mux = 32'(rate[i]);
            end
        end
        if (bus.address_bus == ADDR_MODE) begin
            rd_mux = 32'(mode);
        end
        if (bus.address_bus == ADDR_STATUS) begin
            rd_mux = 32'(led);
        end
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.read_data <= '0;
        end else if (rd_en) begin
            bus.read_data <= rd_mux;
        end
    end
endmodule

// File: tb/tb_led_blink_array.sv
// tb/tb_led_blink_array.sv - scoreboard bench for led_blink_array
module tb_led_blink_array;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] led;

    led_blink_array_if bus_if ();

    led_blink_array #(
        .N          (N),
        .RATE_W     (16),
        .CLK_PER_MS (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .LED   (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } rd_exp_t;

    int      n_checks = 0;
    int      n_fails  = 0;
    int      ecount   = 0;
    rd_exp_t exp_q[$];
    rd_exp_t cur_exp;
    logic    rd_pending = 1'b0;

    // Count non-reset edges; with CLK_PER_MS=4 every 4th one is a tick edge.
    always @(posedge clk) begin
        if (!reset) ecount <= ecount + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a read strobed on an edge is compared at the following negedge.
    always @(negedge clk) begin
        if (rd_pending) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL read_unexpected: got 0x%0h, expected no read", bus_if.read_data);
            end else begin
                cur_exp = exp_q.pop_front();
                check($sformatf("read_addr%0d", cur_exp.addr), bus_if.read_data, cur_exp.data);
            end
        end
        rd_pending = bus_if.chip_select && bus_if.read_enable && !reset;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus_if.chip_select  = 1'b1;
        bus_if.write_enable = 1'b1;
        bus_if.address_bus  = a;
        bus_if.write_data   = d;
        cyc();
        bus_if.chip_select  = 1'b0;
        bus_if.write_enable = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp);
        rd_exp_t e;
        e.addr = a;
        e.data = exp;
        exp_q.push_back(e);
        bus_if.chip_select = 1'b1;
        bus_if.read_enable = 1'b1;
        bus_if.address_bus = a;
        cyc();
        bus_if.chip_select = 1'b0;
        bus_if.read_enable = 1'b0;
    endtask

    task automatic chk_led(input string name, input logic [N-1:0] exp);
        check(name, 32'(led), 32'(exp));
    endtask

    // Advance until the next rising edge is a tick edge.
    task automatic align_tick();
        for (int k = 0; k < 8; k++) begin
            if (((ecount + 1) % 4) == 0) break;
            cyc();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset               = 1'b1;
        bus_if.chip_select  = 1'b0;
        bus_if.read_enable  = 1'b0;
        bus_if.write_enable = 1'b0;
        bus_if.address_bus  = '0;
        bus_if.write_data   = '0;
        repeat (3) cyc();
        reset = 1'b0;

        // Reset state.
        rd(5'd0, 32'h0);
        rd(5'd16, 32'h0);
        rd(5'd18, 32'h0);
        chk_led("led_after_reset", 4'b0000);

        // Continuous blink, ch0 at 3 ms: mode written on a tick edge.
        wr(5'd0, 32'd3);
        rd(5'd0, 32'd3);
        align_tick();
        wr(5'd16, 32'h2);
        chk_led("blink_entry", 4'b0001);
        repeat (11) cyc();
        chk_led("blink_before_toggle1", 4'b0001);
        cyc();
        chk_led("blink_toggle1", 4'b0000);
        repeat (11) cyc();
        chk_led("blink_before_toggle2", 4'b0000);
        cyc();
        chk_led("blink_toggle2", 4'b0001);

        // One-shot on ch3 for 2 ms; ch0 switched off by the same write.
        wr(5'd3, 32'd2);
        align_tick();
        wr(5'd16, 32'hC0);
        check("oneshot_entry", 32'(led[3]), 32'h1);
        repeat (7) cyc();
        chk_led("oneshot_high", 4'b1000);
        cyc();
        chk_led("oneshot_done", 4'b0000);
        rd(5'd16, 32'h0);

        // Shrink rate mid-count: ch0 at 10 ms, cnt reaches 7, then rate becomes 3.
        wr(5'd0, 32'd10);
        align_tick();
        wr(5'd16, 32'h2);
        repeat (29) cyc();
        wr(5'd0, 32'd3);
        cyc();
        chk_led("shrink_before_tick", 4'b0001);
        cyc();
        chk_led("shrink_toggle", 4'b0000);
        rd(5'd16, 32'h2);
        wr(5'd0, 32'h12345);
        rd(5'd0, 32'h2345);
        wr(5'd0, 32'd3);

        // Restart ch0 (blinking) and ch1 (off) on a tick edge.
        align_tick();
        wr(5'd17, 32'h3);
        chk_led("restart_forces_on", 4'b0001);
        rd(5'd18, 32'h1);
        rd(5'd17, 32'h0);
        repeat (9) cyc();
        chk_led("restart_before_toggle", 4'b0001);
        cyc();
        chk_led("restart_toggle", 4'b0000);

        // Reset while ch0 is lit.
        repeat (12) cyc();
        chk_led("pre_reset_lit", 4'b0001);
        reset = 1'b1;
        cyc();
        chk_led("led_in_reset", 4'b0000);
        reset = 1'b0;
        cyc();
        rd(5'd16, 32'h0);
        rd(5'd18, 32'h0);
        rd(5'd0, 32'h0);
        repeat (20) cyc();
        chk_led("stays_off_after_reset", 4'b0000);

        // Reserved address.
        wr(5'd20, 32'hFFFF_FFFF);
        rd(5'd20, 32'h0);
        wr(5'd5, 32'hFFFF_FFFF);
        rd(5'd5, 32'h0);

        repeat (3) cyc();
        check("read_queue_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
